fpu_issue_seq: RTL and testbench
================================

FPU_ISSUE_SEQ -- requirements
Module: fpu_issue_seq

Interface
REQ-001 The module SHALL have parameters, one per line: name, default, meaning.
- LAT_ADD, 4: cycles for FOPADD/FOPSUB.
- LAT_MUL, 5: cycles for FOPMUL.
- LAT_DIV, 16: cycles for FOPDIV.
- LAT_SQRT, 20: cycles for FOPSQRT.
- LAT_SIMPLE, 1: cycles for sign, min/max, compare, convert, move and unrecognised codes.
REQ-002 The module SHALL have ports, one per line: name, direction, width, meaning.
- iCLK, in, 1: the single clock.
- iRST, in, 1: reset, asynchronous, active-low.
- iValid, in, 1: decoded instruction present this cycle.
- iFPALUControl, in, 4: FP operation code from the control decoder.
- iFPRegWrite, in, 1: decoder requests an FP register write.
- iRegWrite, in, 1: decoder requests an integer register write (compare, convert, move).
- iKill, in, 1: abort the in-flight operation.
- oFPStart, out, 1: one-cycle start pulse to the FP ALU.
- oFPOp, out, 4: latched op code, held stable to the FP ALU.
- oStall, out, 1: freeze the PC and instruction.
- oFPRegWriteEn, out, 1: FP register-file write strobe.
- oRegWriteEn, out, 1: integer register-file write strobe.
- oBusy, out, 1: high when the state is not IDLE.
- oIllegal, out, 1: one-cycle flag for an unrecognised op code.

Function
REQ-003 The module SHALL implement three states: IDLE, BUSY, WB.
REQ-004 In IDLE, when iValid=1 and iFPALUControl≠FPOPNULL, the module SHALL, in that cycle:
- assert oFPStart and oStall combinationally;
- latch the op code, iFPRegWrite and iRegWrite;
- load the 5-bit counter with LAT(op)−1.
REQ-005 From the accept cycle, the next state SHALL be WB if LAT(op)=1, otherwise BUSY.
REQ-006 In IDLE with iValid=0 or op=FPOPNULL, all outputs SHALL stay 0 and the state SHALL remain IDLE.
REQ-007 In BUSY, oStall SHALL be 1 and the counter SHALL decrement once per cycle; the state SHALL move to WB in the cycle after the counter reads 1.
REQ-008 For an op of latency L accepted in cycle 0, oStall SHALL be high in cycles 0..L−1 and WB SHALL occur in cycle L.
REQ-009 In WB, the module SHALL:
- hold oStall=0;
- pulse oFPRegWriteEn and oRegWriteEn from the latched flags for exactly one cycle;
- return to IDLE unconditionally, ignoring iValid.
REQ-010 oFPOp SHALL hold the latched code from the accept cycle through WB, and SHALL be FPOPNULL in IDLE.
REQ-011 An unrecognised non-null code SHALL take LAT_SIMPLE cycles, force both write strobes to 0 in WB, and pulse oIllegal in WB.
REQ-012 iKill=1 in BUSY or WB SHALL return the state to IDLE on the next edge, with no write strobe in that cycle.
REQ-013 iKill=1 in IDLE SHALL suppress acceptance in that cycle.
REQ-014 Each latency parameter SHALL lie in 1..31; a value outside this range is a configuration error flagged at elaboration.
REQ-015 If both latched write flags are 1, both strobes SHALL pulse in WB; no arbitration is performed.

Reset
REQ-016 While iRST=0, the state SHALL be IDLE, the counter 0, the latched flags 0, and oFPOp FPOPNULL.
REQ-017 While iRST=0, oFPStart, oStall, oFPRegWriteEn, oRegWriteEn, oBusy and oIllegal SHALL all be 0, asynchronously.
REQ-018 Reset asserted mid-operation SHALL discard the operation with no write strobe.
REQ-019 After iRST deasserts, the module SHALL accept an operation on the first clock edge.

Structure
REQ-020 The FP op codes (FOPADD…FOPCVTSWU, FPOPNULL) and the state encoding SHALL live in the shared parameter package (Parametros); default latencies SHALL be module parameters.
REQ-021 The LAT(op) lookup SHALL be one combinational sub-module, fpu_lat_lut: input 4-bit op, output 5-bit latency plus an illegal flag.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- FOPADD with iFPRegWrite=1, accepted in cycle 0 → oFPStart in cycle 0 only; oStall high in cycles 0–3; oFPRegWriteEn=1 in cycle 4 only; oBusy low from cycle 5.
- FOPSQRT → oStall high for exactly 20 cycles; a single write strobe in cycle 20.
- FOPCLT with iRegWrite=1 → oStall high in cycle 0 only; oRegWriteEn=1 in cycle 1; oFPRegWriteEn stays 0.
- FOPDIV with iKill=1 in cycle 7 → IDLE in cycle 8; no write strobe at any time.
- iRST driven low in cycle 3 of FOPMUL → all outputs 0 immediately, no write strobe; a new FOPADD is accepted on the first edge after iRST releases.
- Unrecognised code 4'hF → oIllegal=1 in cycle 1, both write strobes 0; FPOPNULL with iValid=1 → no stall and no start.

Source files
------------

// File: rtl/fpu_issue_seq_pkg.sv
// Shared FP op codes and issue-sequencer state encoding.
// The null code is 0 so a reset or idle op bus reads as all zeros.
package fpu_issue_seq_pkg;

  localparam logic [3:0] FPOPNULL   = 4'h0;
  localparam logic [3:0] FOPADD     = 4'h1;
  localparam logic [3:0] FOPSUB     = 4'h2;
  localparam logic [3:0] FOPMUL     = 4'h3;
  localparam logic [3:0] FOPDIV     = 4'h4;
  localparam logic [3:0] FOPSQRT    = 4'h5;
  localparam logic [3:0] FOPSGNJ    = 4'h6;
  localparam logic [3:0] FOPMIN     = 4'h7;
  localparam logic [3:0] FOPMAX     = 4'h8;
  localparam logic [3:0] FOPCEQ     = 4'h9;
  localparam logic [3:0] FOPCLT     = 4'hA;
  localparam logic [3:0] FOPCLE     = 4'hB;
  localparam logic [3:0] FOPMV      = 4'hC;
  localparam logic [3:0] FOPCVTSW   = 4'hD;
  localparam logic [3:0] FOPCVTSWU  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic logic lat_ok(input int lat);
    return (lat >= 1) && (lat <= 31);
  endfunction

endpackage

// File: rtl/fpu_issue_seq_lat_lut.sv
// Combinational op-code to latency lookup with an unrecognised-code flag.
module fpu_lat_lut
  import fpu_issue_seq_pkg::*;
#(
  parameter int LAT_ADD    = 4,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 16,
  parameter int LAT_SQRT   = 20,
  parameter int LAT_SIMPLE = 1
) (
  input  logic [3:0] op,
  output logic [4:0] lat,
  output logic       illegal
);

  always_comb begin
    lat     = 5'(LAT_SIMPLE);
    illegal = 1'b0;
    case (op)
      FOPADD, FOPSUB: lat = 5'(LAT_ADD);
      FOPMUL:         lat = 5'(LAT_MUL);
      FOPDIV:         lat = 5'(LAT_DIV);
      FOPSQRT:        lat = 5'(LAT_SQRT);
      FPOPNULL, FOPSGNJ, FOPMIN, FOPMAX, FOPCEQ, FOPCLT, FOPCLE,
      FOPMV, FOPCVTSW, FOPCVTSWU: lat = 5'(LAT_SIMPLE);
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue sequencer for a multi-cycle FP ALU: starts an op, stalls the front end
// for its latency, then emits one write-back strobe.
module fpu_issue_seq
  import fpu_issue_seq_pkg::*;
#(
  parameter int LAT_ADD    = 4,
  parameter int LAT_MUL    = 5,
  parameter int LAT_DIV    = 16,
  parameter int LAT_SQRT   = 20,
  parameter int LAT_SIMPLE = 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iValid,
  input  logic [3:0] iFPALUControl,
  input  logic       iFPRegWrite,
  input  logic       iRegWrite,
  input  logic       iKill,
  output logic       oFPStart,
  output logic [3:0] oFPOp,
  output logic       oStall,
  output logic       oFPRegWriteEn,
  output logic       oRegWriteEn,
  output logic       oBusy,
  output logic       oIllegal
);

  if (!(lat_ok(LAT_ADD) && lat_ok(LAT_MUL) && lat_ok(LAT_DIV) &&
        lat_ok(LAT_SQRT) && lat_ok(LAT_SIMPLE))) begin : g_lat_range
    $error("fpu_issue_seq: every latency parameter must be within 1..31");
  end

  state_t     state;
  logic [4:0] cnt;
  logic [3:0] op_q;
  logic       fpw_q;
  logic       rw_q;
  logic       ill_q;
  logic [4:0] lat;
  logic       lat_ill;
  logic       accept;
  logic       in_wb;

  fpu_lat_lut #(
    .LAT_ADD    (LAT_ADD),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV),
    .LAT_SQRT   (LAT_SQRT),
    .LAT_SIMPLE (LAT_SIMPLE)
  ) u_lat_lut (
    .op      (iFPALUControl),
    .lat     (lat),
    .illegal (lat_ill)
  );

  // Every output is qualified by iRST so reset forces them low without a clock.
  assign accept        = iRST && (state == ST_IDLE) && iValid && !iKill &&
                         (iFPALUControl != FPOPNULL);
  assign in_wb         = iRST && (state == ST_WB) && !iKill;
  assign oFPStart      = accept;
  assign oStall        = accept || (iRST && (state == ST_BUSY));
  assign oBusy         = iRST && (state != ST_IDLE);
  assign oFPRegWriteEn = in_wb && fpw_q && !ill_q;
  assign oRegWriteEn   = in_wb && rw_q && !ill_q;
  assign oIllegal      = in_wb && ill_q;
  assign oFPOp         = accept ? iFPALUControl : (oBusy ? op_q : FPOPNULL);

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= FPOPNULL;
      fpw_q <= 1'b0;
      rw_q  <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= iFPALUControl;
            fpw_q <= iFPRegWrite;
            rw_q  <= iRegWrite;
            ill_q <= lat_ill;
            cnt   <= lat - 5'd1;
            state <= (lat == 5'd1) ? ST_WB : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (iKill) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 5'd1;
            if (cnt <= 5'd1) state <= ST_WB;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
          fpw_q <= 1'b0;
          rw_q  <= 1'b0;
          ill_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Bench for fpu_issue_seq: directed scenarios plus randomized ops against a
// per-cycle timeline model built from op latency, kill and reset points.
module tb_fpu_issue_seq;
  import fpu_issue_seq_pkg::*;

  localparam int L_ADD = 4, L_MUL = 5, L_DIV = 16, L_SQRT = 20, L_SIMPLE = 1;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iValid = 1'b0;
  logic [3:0] iFPALUControl = FPOPNULL;
  logic       iFPRegWrite = 1'b0;
  logic       iRegWrite = 1'b0;
  logic       iKill = 1'b0;
  logic       oFPStart, oStall, oFPRegWriteEn, oRegWriteEn, oBusy, oIllegal;
  logic [3:0] oFPOp;

  int checks = 0;
  int errors = 0;

  fpu_issue_seq #(
    .LAT_ADD(L_ADD), .LAT_MUL(L_MUL), .LAT_DIV(L_DIV),
    .LAT_SQRT(L_SQRT), .LAT_SIMPLE(L_SIMPLE)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .iFPALUControl(iFPALUControl),
    .iFPRegWrite(iFPRegWrite), .iRegWrite(iRegWrite), .iKill(iKill),
    .oFPStart(oFPStart), .oFPOp(oFPOp), .oStall(oStall),
    .oFPRegWriteEn(oFPRegWriteEn), .oRegWriteEn(oRegWriteEn),
    .oBusy(oBusy), .oIllegal(oIllegal)
  );

  always #5 iCLK = ~iCLK;

  function automatic int lat_of(input logic [3:0] op);
    if (op == FOPADD || op == FOPSUB) return L_ADD;
    if (op == FOPMUL) return L_MUL;
    if (op == FOPDIV) return L_DIV;
    if (op == FOPSQRT) return L_SQRT;
    return L_SIMPLE;
  endfunction

  function automatic logic is_known(input logic [3:0] op);
    return op != 4'hF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input logic e_start,
                         input logic e_stall, input logic e_fpw, input logic e_rw,
                         input logic e_busy, input logic e_ill, input logic [3:0] e_op);
    string t;
    t = $sformatf("%s.c%0d", tag, c);
    chk({t, ".start"}, 32'(oFPStart), 32'(e_start));
    chk({t, ".stall"}, 32'(oStall), 32'(e_stall));
    chk({t, ".fpwe"}, 32'(oFPRegWriteEn), 32'(e_fpw));
    chk({t, ".rwe"}, 32'(oRegWriteEn), 32'(e_rw));
    chk({t, ".busy"}, 32'(oBusy), 32'(e_busy));
    chk({t, ".illegal"}, 32'(oIllegal), 32'(e_ill));
    chk({t, ".op"}, 32'(oFPOp), 32'(e_op));
  endtask

  // Present op in cycle 0, then follow it cycle by cycle until it is back in
  // IDLE. kill_at / rst_at are cycle indices (0 = not used).
  task automatic run_op(input string tag, input logic [3:0] op, input logic fpw,
                        input logic rw, input int kill_at, input int rst_at);
    int L, end_c, last;
    logic acc, ill, active, at_wb, in_rst;
    L   = lat_of(op);
    acc = (op != FPOPNULL);
    ill = !is_known(op);
    if (!acc) end_c = -1;
    else if (rst_at != 0) end_c = rst_at - 1;
    else if (kill_at != 0) end_c = kill_at;
    else end_c = L;
    last = (rst_at != 0) ? rst_at : end_c + 1;
    if (last < 1) last = 1;
    for (int c = 0; c <= last; c++) begin
      @(negedge iCLK);
      in_rst = (rst_at != 0) && (c >= rst_at);
      iRST = !in_rst;
      if (c == 0) begin
        iValid = 1'b1; iFPALUControl = op; iFPRegWrite = fpw; iRegWrite = rw;
      end else begin
        iValid = (c <= end_c || in_rst) ? 1'($urandom) : 1'b0;
        if (in_rst) iValid = 1'b1;
        iFPALUControl = 4'($urandom);
        iFPRegWrite = 1'($urandom);
        iRegWrite = 1'($urandom);
      end
      iKill = (kill_at != 0) && (c == kill_at);
      #1;
      active = acc && (c <= end_c);
      at_wb  = active && (c == L);
      chk_all(tag, c,
              active && (c == 0),
              active && (c < L),
              at_wb && (kill_at == 0) && !ill && fpw,
              at_wb && (kill_at == 0) && !ill && rw,
              active && (c >= 1),
              at_wb && ill,
              active ? op : FPOPNULL);
    end
    iKill = 1'b0;
    iValid = 1'b0;
  endtask

  initial begin
    logic [3:0] rop;
    int rk;
    // Reset held with a valid op on the inputs: nothing may leak out.
    iValid = 1'b1; iFPALUControl = FOPADD; iFPRegWrite = 1'b1; iRegWrite = 1'b1;
    @(negedge iCLK); #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, FPOPNULL);
    @(negedge iCLK); #1;
    chk_all("reset", 1, 0, 0, 0, 0, 0, 0, FPOPNULL);

    // Release in the same cycle as the first op: accepted on the first edge.
    run_op("add", FOPADD, 1'b1, 1'b0, 0, 0);
    run_op("sqrt", FOPSQRT, 1'b1, 1'b0, 0, 0);
    run_op("clt", FOPCLT, 1'b0, 1'b1, 0, 0);
    run_op("div_kill", FOPDIV, 1'b1, 1'b1, 7, 0);
    run_op("mul_rst", FOPMUL, 1'b1, 1'b0, 0, 3);
    run_op("add_after_rst", FOPADD, 1'b1, 1'b0, 0, 0);
    run_op("illegal", 4'hF, 1'b1, 1'b1, 0, 0);
    run_op("null", FPOPNULL, 1'b1, 1'b1, 0, 0);
    run_op("mul_both", FOPMUL, 1'b1, 1'b1, 0, 0);
    run_op("add_kill_wb", FOPADD, 1'b1, 1'b1, L_ADD, 0);
    run_op("min_kill_wb", FOPMIN, 1'b1, 1'b1, 1, 0);

    // Kill while idle blocks acceptance.
    @(negedge iCLK);
    iValid = 1'b1; iFPALUControl = FOPDIV; iKill = 1'b1; #1;
    chk_all("kill_idle", 0, 0, 0, 0, 0, 0, 0, FPOPNULL);
    @(negedge iCLK);
    iValid = 1'b0; iKill = 1'b0; #1;
    chk_all("kill_idle", 1, 0, 0, 0, 0, 0, 0, FPOPNULL);

    for (int n = 0; n < 30; n++) begin
      rop = 4'($urandom);
      rk = 0;
      if (rop != FPOPNULL && is_known(rop) && $urandom_range(0, 3) == 0)
        rk = $urandom_range(1, lat_of(rop));
      run_op($sformatf("rnd%0d", n), rop, 1'($urandom), 1'($urandom), rk, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
